// File: rtl/core_pkg.sv
// Shared core definitions: reset vector, NOP encoding,
// fetch-state enum and a word-alignment helper.
package core_pkg;

  localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST       = 32'h0000_0013;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_WAIT,
    F_HOLD
  } fetch_state_e;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/redirect_arb.sv
// Fixed-priority redirect mux: trap over branch over jump.
// Targets come out word aligned.
module redirect_arb
  import core_pkg::*;
(
  input  logic        trap_en,
  input  logic [31:0] trap_addr,
  input  logic        br_en,
  input  logic [31:0] br_addr,
  input  logic        jmp_en,
  input  logic [31:0] jmp_addr,
  output logic        redir_en,
  output logic [31:0] redir_addr
);

  always_comb begin
    redir_en   = trap_en | br_en | jmp_en;
    redir_addr = '0;
    priority case (1'b1)
      trap_en: redir_addr = word_align(trap_addr);
      br_en:   redir_addr = word_align(br_addr);
      jmp_en:  redir_addr = word_align(jmp_addr);
      default: redir_addr = '0;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, one fetch
// in flight, stale responses after a redirect are dropped.
module fetch_ctrl
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_en,
  input  logic [31:0] trap_addr,
  input  logic        br_en,
  input  logic [31:0] br_addr,
  input  logic        jmp_en,
  input  logic [31:0] jmp_addr,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        flush
);

  fetch_state_e state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic         valid_q, valid_d;
  logic         flush_q, flush_d;
  logic         drop_q, drop_d;

  logic         redir_en;
  logic [31:0]  redir_addr;

  redirect_arb u_arb (
    .trap_en    (trap_en),
    .trap_addr  (trap_addr),
    .br_en      (br_en),
    .br_addr    (br_addr),
    .jmp_en     (jmp_en),
    .jmp_addr   (jmp_addr),
    .redir_en   (redir_en),
    .redir_addr (redir_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= F_IDLE;
      addr_q  <= RESET_ADDR;
      pc_q    <= RESET_ADDR;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      drop_q  <= drop_d;
    end
  end

  // addr_q stays put until grant, so it doubles as the in-flight PC
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    drop_d  = drop_q;
    flush_d = 1'b0;
    unique case (state_q)
      F_IDLE: state_d = F_REQ;
      F_REQ: begin
        if (imem_gnt) begin
          state_d = F_WAIT;
          drop_d  = redir_en;
        end
      end
      F_WAIT: begin
        if (imem_rvalid) begin
          drop_d = 1'b0;
          if (redir_en || drop_q) begin
            state_d = F_REQ;
          end else begin
            pc_d    = addr_q;
            inst_d  = imem_rdata;
            valid_d = 1'b1;
            state_d = F_HOLD;
          end
        end else if (redir_en) begin
          drop_d = 1'b1;
        end
      end
      F_HOLD: begin
        if (redir_en) begin
          state_d = F_REQ;
        end else if (!stall) begin
          valid_d = 1'b0;
          addr_d  = pc_q + 32'd4;
          state_d = F_REQ;
        end
      end
      default: state_d = F_IDLE;
    endcase
    if (redir_en && state_q != F_IDLE) begin
      addr_d  = redir_addr;
      flush_d = 1'b1;
      valid_d = 1'b0;
    end
  end

  always_comb begin
    imem_req  = (state_q == F_REQ);
    imem_addr = addr_q;
    if_valid  = valid_q;
    if_pc     = pc_q;
    if_inst   = inst_q;
    flush     = flush_q;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed sequences, redirect table,
// then random traffic against a transaction-level model.
module tb_fetch_ctrl;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trap_en = 1'b0, br_en = 1'b0, jmp_en = 1'b0;
  logic [31:0] trap_addr = '0, br_addr = '0, jmp_addr = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;
  logic        flush;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .trap_en     (trap_en),
    .trap_addr   (trap_addr),
    .br_en       (br_en),
    .br_addr     (br_addr),
    .jmp_en      (jmp_en),
    .jmp_addr    (jmp_addr),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .flush       (flush)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  always @(posedge clk)
    if (!rst && imem_rvalid)
      assert (!imem_req && !if_valid)
        else $error("rvalid outside a pending fetch");

  typedef struct {
    logic [2:0]  en;
    logic [31:0] ta, ba, ja;
    logic        exp_flush;
    logic [31:0] exp_addr;
  } rvec_t;

  rvec_t tbl[8];

  logic        exp_valid, exp_flush, outst, stale, redir, nv;
  logic [31:0] exp_pc, exp_next, out_addr, tgt;
  logic [2:0]  en;
  int          lat, deliveries;

  initial begin
    tbl[0] = '{3'b111, 32'h200, 32'h300, 32'h400, 1'b1, 32'h200};
    tbl[1] = '{3'b011, 32'h200, 32'h300, 32'h400, 1'b1, 32'h300};
    tbl[2] = '{3'b001, 32'h200, 32'h300, 32'h403, 1'b1, 32'h400};
    tbl[3] = '{3'b000, 32'h200, 32'h300, 32'h404, 1'b0, 32'h400};
    tbl[4] = '{3'b100, 32'h1007, 32'h0, 32'h0, 1'b1, 32'h1004};
    tbl[5] = '{3'b010, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'hFFFF_FFFC};
    tbl[6] = '{3'b101, 32'h50, 32'h70, 32'h60, 1'b1, 32'h50};
    tbl[7] = '{3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 32'h50};

    tick; tick;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", if_valid, 0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_inst", if_inst, NOP_INST);
    chk("rst_flush", flush, 0);
    rst = 1'b0;

    // zero-wait fetch at reset vector
    tick;
    chk("req0", imem_req, 1);
    chk("addr0", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    tick;
    chk("wait_req", imem_req, 0);
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0000_0093;
    tick;
    imem_rvalid = 1'b0;
    chk("v0_valid", if_valid, 1);
    chk("v0_pc", if_pc, 32'h0);
    chk("v0_inst", if_inst, 32'h0000_0093);
    stall = 1'b1;
    repeat (5) begin
      tick;
      chk("stall_valid", if_valid, 1);
      chk("stall_pc", if_pc, 32'h0);
      chk("stall_inst", if_inst, 32'h0000_0093);
      chk("stall_req", imem_req, 0);
    end
    stall = 1'b0;
    tick;
    chk("next_req", imem_req, 1);
    chk("next_addr", imem_addr, 32'h4);
    chk("next_valid", if_valid, 0);

    // branch while waiting; late response must be dropped
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0;
    br_en = 1'b1;
    br_addr = 32'h100;
    tick;
    br_en = 1'b0;
    chk("br_flush", flush, 1);
    chk("br_valid", if_valid, 0);
    chk("br_req", imem_req, 0);
    tick;
    chk("br_flush_once", flush, 0);
    tick;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick;
    imem_rvalid = 1'b0;
    chk("br_req2", imem_req, 1);
    chk("br_addr2", imem_addr, 32'h100);
    chk("br_dropped", if_valid, 0);
    chk("br_flush2", flush, 0);
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0010_0093;
    tick;
    imem_rvalid = 1'b0;
    chk("br_valid2", if_valid, 1);
    chk("br_pc2", if_pc, 32'h100);
    chk("br_inst2", if_inst, 32'h0010_0093);

    // jump to top of memory, then wrap
    jmp_en = 1'b1;
    jmp_addr = 32'hFFFF_FFFE;
    tick;
    jmp_en = 1'b0;
    chk("j_flush", flush, 1);
    chk("j_req", imem_req, 1);
    chk("j_addr", imem_addr, 32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0000_0013;
    tick;
    imem_rvalid = 1'b0;
    chk("top_pc", if_pc, 32'hFFFF_FFFC);
    chk("top_valid", if_valid, 1);
    tick;
    chk("wrap_req", imem_req, 1);
    chk("wrap_addr", imem_addr, 32'h0);

    // redirect priority table, applied while requesting
    for (int i = 0; i < 8; i++) begin
      trap_en = tbl[i].en[2];
      br_en = tbl[i].en[1];
      jmp_en = tbl[i].en[0];
      trap_addr = tbl[i].ta;
      br_addr = tbl[i].ba;
      jmp_addr = tbl[i].ja;
      tick;
      chk($sformatf("tbl%0d_flush", i), flush, tbl[i].exp_flush);
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
    end
    trap_en = 1'b0;
    br_en = 1'b0;
    jmp_en = 1'b0;

    // reset mid-fetch, then a late response
    imem_gnt = 1'b1;
    tick;
    imem_gnt = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("r_idle_req", imem_req, 0);
    chk("r_idle_addr", imem_addr, 32'h0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick;
    imem_rvalid = 1'b0;
    chk("r_req", imem_req, 1);
    chk("r_addr", imem_addr, 32'h0);
    chk("r_valid", if_valid, 0);
    tick;
    chk("r_valid2", if_valid, 0);

    // random traffic
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    exp_valid = 1'b0;
    exp_flush = 1'b0;
    exp_next = 32'h0;
    exp_pc = 32'h0;
    outst = 1'b0;
    stale = 1'b0;
    out_addr = 32'h0;
    lat = 0;
    deliveries = 0;
    for (int i = 0; i < 3000; i++) begin
      tick;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      trap_en = 1'b0;
      br_en = 1'b0;
      jmp_en = 1'b0;
      chk("rnd_flush", flush, exp_flush);
      chk("rnd_valid", if_valid, exp_valid);
      if (exp_valid) begin
        chk("rnd_pc", if_pc, exp_pc);
        chk("rnd_inst", if_inst, memf(exp_pc));
      end
      chk("rnd_req_hold", imem_req & if_valid, 0);
      if (outst) chk("rnd_req_outst", imem_req, 0);

      stall = 1'($urandom % 2);
      redir = ($urandom % 8 == 0);
      en = redir ? 3'($urandom_range(1, 7)) : 3'b000;
      trap_en = en[2];
      br_en = en[1];
      jmp_en = en[0];
      trap_addr = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      br_addr = $urandom;
      jmp_addr = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      tgt = en[2] ? trap_addr : en[1] ? br_addr : jmp_addr;
      tgt[1:0] = 2'b00;
      if (outst) begin
        if (lat == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = memf(out_addr);
        end else begin
          lat--;
        end
      end
      if (imem_req && ($urandom % 3 != 0)) imem_gnt = 1'b1;

      nv = exp_valid;
      if (redir && outst) stale = 1'b1;
      if (imem_gnt) begin
        chk("rnd_fetch_addr", imem_addr, exp_next);
        outst = 1'b1;
        stale = redir;
        out_addr = exp_next;
        lat = int'($urandom % 3);
      end else if (imem_rvalid) begin
        outst = 1'b0;
        if (!stale) begin
          nv = 1'b1;
          exp_pc = out_addr;
          deliveries++;
        end
      end
      if (exp_valid && !stall && !redir) begin
        nv = 1'b0;
        exp_next = exp_pc + 32'd4;
      end
      if (redir) begin
        nv = 1'b0;
        exp_next = tgt;
      end
      exp_valid = nv;
      exp_flush = redir;
    end
    chk("rnd_progress", 32'(deliveries >= 100), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the single-issue RISC-V core. It owns the fetch PC, arbitrates redirect requests from trap, branch and jump sources, and drives a request/grant/response handshake to instruction memory. It delivers one instruction at a time to decode, honouring decode back-pressure and discarding stale responses after a redirect. It sits between the hazard/execute logic and the imem port, and replaces direct `jump_en`/`jump_addr` control of the PC.

## Interface
- `RESET_ADDR`, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- `clk`  in  1  core clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `trap_en` / `trap_addr`  in  1 / 32  trap redirect, highest priority
- `br_en` / `br_addr`  in  1 / 32  taken-branch redirect from EX
- `jmp_en` / `jmp_addr`  in  1 / 32  jump redirect from ID, lowest priority
- `stall`  in  1  decode cannot accept `if_*` this cycle
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address, word aligned
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid` / `imem_rdata`  in  1 / 32  response, at least 1 cycle after gnt
- `if_valid` / `if_pc` / `if_inst`  out  1 / 32 / 32  instruction to decode
- `flush`  out  1  one-cycle pulse: a redirect was taken, decode drops its contents

## Operation
- States: IDLE, REQ, WAIT, HOLD.
- Reset values: state IDLE; `imem_req`=0; `imem_addr`=RESET_ADDR; `if_valid`=0; `if_pc`=RESET_ADDR; `if_inst`=32'h0000_0013 (nop); `flush`=0; drop flag 0.
- IDLE -> REQ unconditionally on the first cycle after `rst` deasserts.
- REQ:
  - `imem_req`=1.
  - On `imem_gnt`: -> WAIT, latch `imem_addr` as the in-flight PC.
- WAIT:
  - On `imem_rvalid` with drop=0: capture `if_inst`/`if_pc`, set `if_valid` -> HOLD.
  - On `imem_rvalid` with drop=1: clear drop, discard the data -> REQ.
- HOLD:
  - While `stall`=1, `if_*` are held stable.
  - When `stall`=0: drop `if_valid`, `imem_addr` <= `if_pc`+4 -> REQ.
- Redirect:
  - Active when any `*_en` is high; priority trap > br > jmp. Target bits [1:0] are forced to 0.
  - In any state except IDLE: `imem_addr` <= target, `flush`=1 next cycle, `if_valid` <= 0.
  - Next state: REQ from REQ and HOLD. From WAIT, stay in WAIT with drop=1, or go to REQ if `imem_rvalid` arrives in the same cycle.
  - Redirect in REQ with `imem_gnt` high in the same cycle: the granted fetch is treated as stale -> WAIT with drop=1.
- PC arithmetic is modulo 2^32: `if_pc` 32'hFFFF_FFFC + 4 -> 32'h0.
- At most one fetch outstanding. No prefetch.

## Timing
- `imem_req` may retarget `imem_addr` before grant only because of a redirect. Otherwise the address is stable until `imem_gnt`.
- Zero-wait memory: req/gnt in cycle N, rvalid in N+1, `if_valid` high in N+2, next req in N+3 if `stall`=0. Throughput is one instruction per 3 cycles.
- Redirect seen in cycle N: `flush` high and `if_valid` low in N+1. Request to the target is on `imem_addr` in N+1.
- `rst` mid-transaction returns to IDLE immediately. An `imem_rvalid` arriving after reset is ignored: IDLE and REQ do not sample rvalid.
- `imem_rvalid` in REQ or HOLD is a protocol error. It is ignored, with an assertion in the bench.

## Structure
- Shared package `core_pkg`: `RESET_ADDR` default, NOP encoding 32'h0000_0013, fetch-state enum.
- The redirect priority mux is a natural sub-module, `redirect_arb`: combinational, 3 requesters -> `redir_en`, `redir_addr`. All other logic is in one FSM module.

## Test plan
- Reset release, zero-wait memory returning 32'h0000_0093 at 0x0: `imem_req` addr 0x0 on the cycle after reset; `if_valid` 2 cycles later with `if_pc`=0x0; next req at 0x4.
- `stall` held 5 cycles in HOLD: `if_pc`/`if_inst` unchanged, `imem_req`=0 throughout; fetch to `if_pc`+4 on the cycle after release.
- `br_en`=1, `br_addr`=0x100 while in WAIT with rvalid 3 cycles later: `flush` pulses once, the rvalid data is discarded, next req goes to 0x100, and `if_pc`=0x100 is delivered.
- `trap_en`, `br_en` and `jmp_en` asserted together with targets 0x200/0x300/0x400: fetch goes to 0x200. A `jmp_addr` of 0x403 fetches 0x400.
- `if_pc`=0xFFFF_FFFC consumed: next req address is 0x0.
- `rst` asserted in WAIT, then rvalid arrives: `if_valid` stays 0 and the first post-reset req goes to RESET_ADDR.
